// File: rtl/wb_data_cache_stage_pkg.sv
// Shared definitions for the write-back data cache stage: load codes, FSM states
// and default cache geometry.
package wb_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd3;
  localparam logic [2:0] LHU = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL
  } state_e;

  localparam int unsigned DEF_LINE_ADDR_LEN = 3;
  localparam int unsigned DEF_SET_ADDR_LEN  = 4;
  localparam int unsigned DEF_MEM_ADDR_LEN  = 16;
  localparam int unsigned DEF_TAG_LEN       = DEF_MEM_ADDR_LEN - DEF_SET_ADDR_LEN - DEF_LINE_ADDR_LEN;
  localparam int unsigned DEF_WORDS         = 1 << DEF_LINE_ADDR_LEN;
  localparam int unsigned DEF_SETS          = 1 << DEF_SET_ADDR_LEN;

endpackage

// File: rtl/wb_data_cache_stage_load_extend.sv
// Load data extension: picks the addressed byte/half of a word and sign/zero fills it.
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      load_type,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] data_out
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = data_in[{offset, 3'b000} +: 8];
    half_v   = data_in[{offset[1], 4'b0000} +: 16];
    data_out = data_in;
    case (load_type)
      LB:      data_out = {{(XLEN-8){byte_v[7]}}, byte_v};
      LBU:     data_out = {{(XLEN-8){1'b0}}, byte_v};
      LH:      data_out = {{(XLEN-16){half_v[15]}}, half_v};
      LHU:     data_out = {{(XLEN-16){1'b0}}, half_v};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/wb_data_cache_stage.sv
// MEM/WB stage with a direct-mapped write-back data cache and word-serial memory port.
// Define WB_CACHE_STATS_EN to implement the hit/access counters (tied to 0 otherwise).
module wb_data_cache_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int unsigned SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
  parameter int unsigned MEM_ADDR_LEN  = DEF_MEM_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bubbleW,
  input  logic                    flushW,
  input  logic                    wb_select,
  input  logic [2:0]              load_type,
  input  logic [XLEN/8-1:0]       write_en,
  input  logic [XLEN-1:0]         addr,
  input  logic [XLEN-1:0]         in_data,
  output logic [XLEN-1:0]         data_WB,
  output logic                    miss,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [MEM_ADDR_LEN-1:0] mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  input  logic                    mem_ack,
  input  logic [XLEN-1:0]         mem_rdata,
  output logic [31:0]             hit_count,
  output logic [31:0]             access_count
);

  localparam int unsigned LANES   = XLEN / 8;
  localparam int unsigned TAG_LEN = MEM_ADDR_LEN - SET_ADDR_LEN - LINE_ADDR_LEN;
  localparam int unsigned WORDS   = 1 << LINE_ADDR_LEN;
  localparam int unsigned SETS    = 1 << SET_ADDR_LEN;

  logic [LINE_ADDR_LEN-1:0] word_idx;
  logic [SET_ADDR_LEN-1:0]  set_idx;
  logic [TAG_LEN-1:0]       tag;
  logic                     unused_addr_hi;

  assign word_idx       = addr[2 +: LINE_ADDR_LEN];
  assign set_idx        = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
  assign tag            = addr[SET_ADDR_LEN+LINE_ADDR_LEN+2 +: TAG_LEN];
  assign unused_addr_hi = ^addr[XLEN-1:MEM_ADDR_LEN+2];

  state_e                   state_q;
  logic [LINE_ADDR_LEN-1:0] cnt_q;
  logic [SETS-1:0]          valid_q;
  logic [SETS-1:0]          dirty_q;
  logic [TAG_LEN-1:0]       tag_q [SETS];
  logic                     mem_req_q;
  logic                     mem_we_q;
  logic [XLEN-1:0]          data_q [SETS][WORDS];
  logic [XLEN-1:0]          rdata_q;

  logic            req;
  logic            hit;
  logic            access_hit;
  logic            store_hit;
  logic            refill_wr;
  logic            last;
  logic [LANES-1:0] st_mask;
  logic [XLEN-1:0]  st_data;

  assign req        = (wb_select | (|write_en)) & ~flushW;
  assign hit        = valid_q[set_idx] && (tag_q[set_idx] == tag);
  assign miss       = req && ((state_q != IDLE) || !hit);
  assign access_hit = req && (state_q == IDLE) && hit;
  assign store_hit  = access_hit && (|write_en);
  assign refill_wr  = (state_q == REFILL) && mem_ack;
  assign last       = (cnt_q == '1);
  assign st_mask    = write_en << addr[1:0];
  assign st_data    = in_data << {addr[1:0], 3'b000};

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = {((state_q == WB) ? tag_q[set_idx] : tag), set_idx, cnt_q};
  assign mem_wdata = data_q[set_idx][cnt_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) tag_q[s] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (store_hit) dirty_q[set_idx] <= 1'b1;
          if (miss) begin
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            if (valid_q[set_idx] && dirty_q[set_idx]) begin
              state_q  <= WB;
              mem_we_q <= 1'b1;
            end else begin
              state_q  <= REFILL;
              mem_we_q <= 1'b0;
            end
          end
        end
        WB: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              state_q  <= REFILL;
              cnt_q    <= '0;
              mem_we_q <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              state_q          <= IDLE;
              cnt_q            <= '0;
              mem_req_q        <= 1'b0;
              valid_q[set_idx] <= 1'b1;
              dirty_q[set_idx] <= 1'b0;
              tag_q[set_idx]   <= tag;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data array has no reset; the read port is sampled every cycle and only
  // consumed when the registered wb_select says so.
  always_ff @(posedge clk) begin
    rdata_q <= data_q[set_idx][word_idx];
    if (refill_wr) begin
      data_q[set_idx][cnt_q] <= mem_rdata;
    end else if (store_hit) begin
      for (int unsigned b = 0; b < LANES; b++)
        if (st_mask[b]) data_q[set_idx][word_idx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

  logic            bubble_ff_q;
  logic            flush_ff_q;
  logic            wb_select_q;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      load_type_q;
  logic [XLEN-1:0] data_wb_q;
  logic [XLEN-1:0] ext_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_ff_q <= 1'b0;
      flush_ff_q  <= 1'b0;
      wb_select_q <= 1'b0;
      addr_q      <= '0;
      load_type_q <= '0;
      data_wb_q   <= '0;
    end else begin
      bubble_ff_q <= bubbleW;
      flush_ff_q  <= flushW;
      wb_select_q <= wb_select;
      addr_q      <= addr;
      load_type_q <= load_type;
      data_wb_q   <= data_WB;
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .load_type (load_type_q),
    .offset    (addr_q[1:0]),
    .data_in   (rdata_q),
    .data_out  (ext_data)
  );

  assign data_WB = bubble_ff_q ? data_wb_q :
                   flush_ff_q  ? '0 :
                   wb_select_q ? ext_data : addr_q;

`ifdef WB_CACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] acc_q;
  logic        missed_q;

  // An access that missed is counted once, on the cycle it finally hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q    <= '0;
      acc_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && miss) missed_q <= 1'b1;
      if (access_hit) begin
        missed_q <= 1'b0;
        if (acc_q != '1) acc_q <= acc_q + 32'd1;
        if (!missed_q && (hit_q != '1)) hit_q <= hit_q + 32'd1;
      end
    end
  end

  assign hit_count    = hit_q;
  assign access_count = acc_q;
`else
  assign hit_count    = '0;
  assign access_count = '0;
`endif

endmodule

// File: tb/tb_wb_data_cache_stage.sv
// Directed self-checking bench for wb_data_cache_stage with a word-serial memory responder.
module tb_wb_data_cache_stage;
  import wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        bubbleW;
  logic        flushW;
  logic        wb_select;
  logic [2:0]  load_type;
  logic [3:0]  write_en;
  logic [31:0] addr;
  logic [31:0] in_data;
  logic [31:0] data_WB;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] access_count;

  wb_data_cache_stage dut (
    .clk          (clk),
    .rst          (rst),
    .bubbleW      (bubbleW),
    .flushW       (flushW),
    .wb_select    (wb_select),
    .load_type    (load_type),
    .write_en     (write_en),
    .addr         (addr),
    .in_data      (in_data),
    .data_WB      (data_WB),
    .miss         (miss),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .hit_count    (hit_count),
    .access_count (access_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [31:0] d;
  } xfer_t;

  xfer_t       log_q[$];
  logic [31:0] mem_m [0:511];

  // Memory acknowledges every requested word one cycle at a time.
  initial begin
    for (int i = 0; i < 512; i++) mem_m[i] = 32'h1000_0000 + i;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        log_q.push_back('{mem_we, mem_addr, mem_wdata});
        if (mem_we) mem_m[mem_addr[8:0]] = mem_wdata;
        mem_rdata = mem_m[mem_addr[8:0]];
        mem_ack   = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef WB_CACHE_STATS_EN
    return v;
`else
    return v & 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ws, input logic [2:0] lt, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] d);
    wb_select = ws;
    load_type = lt;
    write_en  = we;
    addr      = a;
    in_data   = d;
    #1;
  endtask

  task automatic wait_fill(input int budget);
    int n = 0;
    while (miss && n < budget) begin
      tick();
      n++;
    end
    chk("fill_done", {31'd0, miss}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bubbleW = 1'b0; flushW = 1'b0;
    wb_select = 1'b0; load_type = LB; write_en = '0; addr = '0; in_data = '0;
    tick(); tick();
    chk("rst_data_WB", data_WB, 32'd0);
    chk("rst_miss", {31'd0, miss}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_access", access_count, 32'd0);
    chk("rst_hit", hit_count, 32'd0);
    rst = 1'b0;
    tick();

    // Cold load: refill words 0..7 of set 0
    log_q.delete();
    drive(1'b1, LW, 4'd0, 32'h10, 32'd0);
    chk("cold_miss", {31'd0, miss}, 32'd1);
    wait_fill(40);
    chk("refill_len", log_q.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      chk("refill_xfer", {15'd0, log_q[i].we, log_q[i].a}, i);
    tick();
    chk("cold_lw", data_WB, 32'h1000_0004);

    // Byte store then loads of every kind
    drive(1'b0, LB, 4'b0001, 32'h11, 32'h80);
    chk("sb_no_miss", {31'd0, miss}, 32'd0);
    tick();
    chk("sb_alu_path", data_WB, 32'h11);
    drive(1'b1, LBU, 4'd0, 32'h11, 32'd0); tick();
    chk("lbu", data_WB, 32'h0000_0080);
    drive(1'b1, LB, 4'd0, 32'h11, 32'd0); tick();
    chk("lb", data_WB, 32'hFFFF_FF80);
    drive(1'b1, LH, 4'd0, 32'h10, 32'd0); tick();
    chk("lh", data_WB, 32'hFFFF_8004);
    drive(1'b1, LHU, 4'd0, 32'h12, 32'd0); tick();
    chk("lhu_upper", data_WB, 32'h0000_1000);
    drive(1'b1, LW, 4'd0, 32'h10, 32'd0); tick();
    chk("lw_after_sb", data_WB, 32'h1000_8004);

    // Bubble holds the previous value
    bubbleW = 1'b1;
    drive(1'b0, LW, 4'd0, 32'h14, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bubble_hold", data_WB, 32'h1000_8004);
    end
    bubbleW = 1'b0;
    drive(1'b1, LW, 4'd0, 32'h14, 32'd0); tick();
    chk("after_bubble", data_WB, 32'h1000_0005);

    // Flushed store must not write
    flushW = 1'b1;
    drive(1'b0, LB, 4'b0001, 32'h14, 32'h55); tick();
    chk("flush_zero", data_WB, 32'd0);
    flushW = 1'b0;
    drive(1'b1, LW, 4'd0, 32'h14, 32'd0); tick();
    chk("flush_no_write", data_WB, 32'h1000_0005);
    chk("acc_mid", access_count, stat(32'd9));
    chk("hit_mid", hit_count, stat(32'd8));

    // Dirty eviction by tag 1 in set 0
    log_q.delete();
    drive(1'b1, LW, 4'd0, 32'h200, 32'd0);
    chk("evict_miss", {31'd0, miss}, 32'd1);
    wait_fill(60);
    chk("evict_len", log_q.size(), 32'd16);
    chk("evict_wb0", {15'd0, log_q[0].we, log_q[0].a}, 32'h0001_0000);
    chk("evict_wb4_data", log_q[4].d, 32'h1000_8004);
    chk("evict_wb7", {15'd0, log_q[7].we, log_q[7].a}, 32'h0001_0007);
    chk("evict_rf0", {15'd0, log_q[8].we, log_q[8].a}, 32'h0000_0080);
    chk("evict_rf7", {15'd0, log_q[15].we, log_q[15].a}, 32'h0000_0087);
    tick();
    chk("evict_data", data_WB, 32'h1000_0080);

    // Reload the evicted line: clean victim, refill sees written-back data
    log_q.delete();
    drive(1'b1, LW, 4'd0, 32'h10, 32'd0);
    chk("reload_miss", {31'd0, miss}, 32'd1);
    wait_fill(40);
    chk("reload_len", log_q.size(), 32'd8);
    tick();
    chk("reload_data", data_WB, 32'h1000_8004);
    chk("acc_pre_rst", access_count, stat(32'd11));
    chk("hit_pre_rst", hit_count, stat(32'd8));

    // Reset during refill word 3
    log_q.delete();
    drive(1'b1, LW, 4'd0, 32'h30, 32'd0);
    tick(); tick(); tick(); tick();
    chk("mid_req", {31'd0, mem_req}, 32'd1);
    chk("mid_addr", {16'd0, mem_addr}, 32'h0000_000B);
    rst = 1'b1;
    #1;
    chk("abort_req", {31'd0, mem_req}, 32'd0);
    chk("abort_acc", access_count, 32'd0);
    chk("abort_hit", hit_count, 32'd0);
    chk("abort_data_WB", data_WB, 32'd0);
    rst = 1'b0;
    #1;
    chk("remiss", {31'd0, miss}, 32'd1);
    wait_fill(40);
    tick();
    chk("remiss_data", data_WB, 32'h1000_000C);

    // Three hits then one more miss
    drive(1'b1, LW, 4'd0, 32'h34, 32'd0); tick();
    chk("hit_34", data_WB, 32'h1000_000D);
    drive(1'b1, LW, 4'd0, 32'h38, 32'd0); tick();
    chk("hit_38", data_WB, 32'h1000_000E);
    drive(1'b1, LW, 4'd0, 32'h3C, 32'd0); tick();
    chk("hit_3c", data_WB, 32'h1000_000F);
    drive(1'b1, LW, 4'd0, 32'h40, 32'd0);
    chk("miss_40", {31'd0, miss}, 32'd1);
    wait_fill(40);
    tick();
    chk("data_40", data_WB, 32'h1000_0010);
    chk("acc_final", access_count, stat(32'd5));
    chk("hit_final", hit_count, stat(32'd3));
    drive(1'b0, LB, 4'd0, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_data_cache_stage.md
Name: wb_data_cache_stage

Overview:
MEM/WB write-back data stage for the RV32I core. It integrates a parametrised direct-mapped write-back data cache, load data extension, and bubble/flush hold logic. It is the successor of the fixed-geometry WB data seg reg: configurable width and geometry, dirty-line write-back, a word-serial req/ack memory port, and a stall (miss) output.

Parameters:
XLEN, 32, data/address width; byte lanes = XLEN/8
LINE_ADDR_LEN, 3, log2 words per line
SET_ADDR_LEN, 4, log2 number of sets (direct-mapped)
MEM_ADDR_LEN, 16, word-address width of the backing memory; tag = MEM_ADDR_LEN-SET_ADDR_LEN-LINE_ADDR_LEN

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
bubbleW  in  1  hold WB output
flushW  in  1  clear WB output, suppress access
wb_select  in  1  1=load result, 0=ALU result (addr)
load_type  in  3  load kind (pkg codes)
write_en  in  XLEN/8  store byte mask, lane-0 aligned
addr  in  XLEN  byte address / ALU result
in_data  in  XLEN  store data, lane-0 aligned
data_WB  out  XLEN  write-back register data
miss  out  1  stall request to hazard unit
mem_req  out  1  memory word request
mem_we  out  1  1=write-back word, 0=refill word
mem_addr  out  MEM_ADDR_LEN  word address
mem_wdata  out  XLEN  write-back data
mem_ack  in  1  word transfer done; mem_rdata valid this cycle
mem_rdata  in  XLEN  refill data
hit_count  out  32  hit counter
access_count  out  32  access counter

Behaviour:
- Reset (async): FSM=IDLE; all valid/dirty=0; data_WB=0; miss=0; mem_req=0; counters=0. Reset mid-transfer aborts it; mem_req drops immediately.
- Access request = (wb_select | |write_en) & ~flushW. Word index = addr[LINE_ADDR_LEN+1:2], set and tag from the bits above.
- miss is combinational: 1 when a request is present in IDLE and the line is invalid or the tag mismatches; held until the FSM returns to IDLE with the line filled. The pipeline keeps inputs stable while miss=1.
- Hit load: data is read at the clk edge; data_WB is valid the next cycle (1-cycle latency).
- Hit store: write_en and in_data are shifted by addr[1:0] lanes, written at the edge, and set dirty.
- FSM states:
  - IDLE, on miss: dirty -> WB, else REFILL.
  - WB: mem_req=1, mem_we=1, mem_addr={old tag,set,cnt}; cnt advances on mem_ack; after the last word -> REFILL.
  - REFILL: mem_req=1, mem_we=0, mem_addr={new tag,set,cnt}; mem_rdata is written on mem_ack; after the last word, set valid/tag, clear dirty -> IDLE. The access then hits.
- cnt is LINE_ADDR_LEN bits and wraps to 0 on each state entry.
- Output path registers bubble_ff, flush_ff, wb_select_q, addr_q, load_type_q.
  - data_WB = bubble_ff ? previous data_WB : flush_ff ? 0 : wb_select_q ? extended : addr_q.
  - bubble has priority over flush.
- Extension (load_type_q, addr_q[1:0]):
  - LB/LBU select the byte at addr_q[1:0].
  - LH/LHU select the half at addr_q[1].
  - LW ignores addr_q[1:0].
  - Sign or zero fill to XLEN.
- load_type and write_en both nonzero is illegal: store wins; no load extension is guaranteed.
- Counters saturate at 32'hFFFF_FFFF and count once per completed access (a missed access counts on its final hit cycle as a non-hit).

Optional Feature:
- Macro: WB_CACHE_STATS_EN.
- Defined: hit_count/access_count are implemented as above.
- Undefined: no counter flops; both outputs are tied to 0.

Decomposition:
- Package wb_pkg:
  - load_type codes: LB=3'd0, LH=3'd1, LW=3'd2, LBU=3'd3, LHU=3'd4.
  - FSM enum: IDLE, WB, REFILL.
  - localparams for tag width, words per line and sets.
- Sub-module load_extend: combinational byte/half select plus sign/zero extension.

Test Plan:
- Reset, then LW 0x0000_0010 (cold): miss=1; REFILL issues mem_addr 0x0000..0x0007 with mem_ack each cycle; data_WB equals mem word 4 one cycle after miss falls.
- SB 0x80 at addr 0x11, then LBU 0x11 -> 0x0000_0080; LB 0x11 -> 0xFFFF_FF80; LH 0x10 -> sign-extended {0x80,byte0}.
- Dirty line evicted by a same-set, different-tag load: WB writes 8 words with mem_we=1 and the old tag, then REFILL reads 8 words; written data appears on mem_wdata.
- bubbleW=1 for 3 cycles after a valid load: data_WB holds the value. flushW=1 with a store: no cache write; the next load of that addr returns the old data; data_WB=0 one cycle later.
- rst asserted during REFILL word 3: mem_req=0 in the same cycle; the subsequent load misses again; counters=0.
- WB_CACHE_STATS_EN defined, 2 misses + 3 hits -> access_count=5, hit_count=3; undefined -> both 0.
